// File: rtl/fir_pkg.sv
// Shared constants for the 3-tap FIR filter slice.
package fir_pkg;
    localparam int unsigned FIR_WIDTH = 8;
    localparam int unsigned FIR_TAPS  = 3;
endpackage

// File: rtl/fir_tap_mac.sv
// One FIR tap: unsigned WIDTH x WIDTH product at full 2*WIDTH precision.
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_WIDTH
) (
    input  logic [WIDTH-1:0]   w,
    input  logic [WIDTH-1:0]   x,
    output logic [2*WIDTH-1:0] prod_c
);
    localparam int unsigned PW = 2 * WIDTH;

    assign prod_c = PW'(w) * PW'(x);
endmodule

// File: rtl/fir_filter.sv
// 3-tap direct-form FIR: registered delay line, per-tap multipliers,
// wrapping adder tree and a registered output.
module fir_filter
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = FIR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     fir_in,
    input  logic [WIDTH-1:0]     w_1,
    input  logic [WIDTH-1:0]     w_2,
    input  logic [WIDTH-1:0]     w_3,
    output logic [2*WIDTH-1:0]   fir_out
);
    localparam int unsigned OW = 2 * WIDTH;

    // taps[0] is x1 (newest), taps[FIR_TAPS-1] is x3 (oldest)
    logic [WIDTH-1:0] taps   [FIR_TAPS];
    logic [WIDTH-1:0] coef   [FIR_TAPS];
    logic [OW-1:0]    prod_c [FIR_TAPS];
    logic [OW-1:0]    sum_c;

    assign coef[0] = w_1;
    assign coef[1] = w_2;
    assign coef[2] = w_3;

    for (genvar i = 0; i < FIR_TAPS; i++) begin : g_tap
        fir_tap_mac #(.WIDTH(WIDTH)) u_mac (
            .w      (coef[i]),
            .x      (taps[i]),
            .prod_c (prod_c[i])
        );
    end

    // Sum stays at OW bits so the carry-out is dropped (modular wrap).
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < FIR_TAPS; i++) begin
            sum_c = sum_c + prod_c[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIR_TAPS; i++) begin
                taps[i] <= '0;
            end
            fir_out <= '0;
        end else begin
            taps[0] <= fir_in;
            for (int unsigned i = 1; i < FIR_TAPS; i++) begin
                taps[i] <= taps[i-1];
            end
            fir_out <= sum_c;
        end
    end
endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: directed samples with hand-computed outputs.
module tb_fir_filter;
    logic        clk;
    logic        rst;
    logic [7:0]  fir_in;
    logic [7:0]  w_1, w_2, w_3;
    logic [15:0] fir_out;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    fir_filter #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .fir_in  (fir_in),
        .w_1     (w_1),
        .w_2     (w_2),
        .w_3     (w_3),
        .fir_out (fir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected output per queued entry, sampled 1 unit after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (fir_out !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s: fir_out=0x%04h expected 0x%04h", mon_e.name, fir_out, mon_e.exp);
            end
        end
    end

    // Drive one sample and weights before the next edge; queue the output after that edge.
    task automatic step(input logic [7:0] fin, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [15:0] exp, input string name);
        sb_t e;
        @(negedge clk);
        fir_in = fin;
        w_1 = a;
        w_2 = b;
        w_3 = c;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [15:0] exp);
        n_checks++;
        if (fir_out !== exp) begin
            n_fail++;
            $display("FAIL %s: fir_out=0x%04h expected 0x%04h", name, fir_out, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        fir_in = '0;
        w_1 = '0;
        w_2 = '0;
        w_3 = '0;

        // Asynchronous reset before the first edge
        #2 rst = 1'b1;
        #1 check_now("reset_async_initial", 16'h0000);
        repeat (2) begin
            @(negedge clk);
            check_now("reset_held", 16'h0000);
        end
        rst = 1'b0;
        step(8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, "post_reset_0");
        step(8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, "post_reset_1");
        step(8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, "post_reset_2");

        // Two-sample impulse pattern, weights 5B/FF/87
        step(8'hFF, 8'h5B, 8'hFF, 8'h87, 16'h0000, "imp_e0");
        step(8'h00, 8'h5B, 8'hFF, 8'h87, 16'h5AA5, "imp_e1");
        step(8'hFF, 8'h5B, 8'hFF, 8'h87, 16'hFE01, "imp_e2");
        step(8'h00, 8'h5B, 8'hFF, 8'h87, 16'hE11E, "imp_e3");
        step(8'h00, 8'h5B, 8'hFF, 8'h87, 16'hFE01, "imp_e4");
        step(8'h00, 8'h5B, 8'hFF, 8'h87, 16'h8679, "imp_e5");
        step(8'h00, 8'h5B, 8'hFF, 8'h87, 16'h0000, "imp_e6");
        step(8'h00, 8'h5B, 8'hFF, 8'h87, 16'h0000, "imp_e7");

        // Single unit impulse exposes each tap weight in order
        step(8'h01, 8'h11, 8'h22, 8'h33, 16'h0000, "unit_e0");
        step(8'h00, 8'h11, 8'h22, 8'h33, 16'h0011, "unit_w1");
        step(8'h00, 8'h11, 8'h22, 8'h33, 16'h0022, "unit_w2");
        step(8'h00, 8'h11, 8'h22, 8'h33, 16'h0033, "unit_w3");
        step(8'h00, 8'h11, 8'h22, 8'h33, 16'h0000, "unit_done");

        // Full-scale input and weights: sum wraps modulo 2^16
        step(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h0000, "wrap_e0");
        step(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFE01, "wrap_e1");
        step(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFC02, "wrap_e2");
        step(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFA03, "wrap_e3");
        step(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFA03, "wrap_steady");

        // Constant 0x02 input, then w_2 changes 0x01 -> 0x10
        step(8'h02, 8'h01, 8'h01, 8'h01, 16'h02FD, "coef_flush0");
        step(8'h02, 8'h01, 8'h01, 8'h01, 16'h0200, "coef_flush1");
        step(8'h02, 8'h01, 8'h01, 8'h01, 16'h0103, "coef_flush2");
        step(8'h02, 8'h01, 8'h01, 8'h01, 16'h0006, "coef_old_w2");
        step(8'h02, 8'h01, 8'h10, 8'h01, 16'h0024, "coef_new_w2");
        step(8'h02, 8'h01, 8'h10, 8'h01, 16'h0024, "coef_new_w2_hold");

        // Mid-stream asynchronous reset while fir_out is nonzero
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_now("reset_async_midstream", 16'h0000);
        repeat (2) begin
            @(negedge clk);
            check_now("reset_mid_held", 16'h0000);
        end
        fir_in = 8'h00;
        rst = 1'b0;

        // History must be zero after reset
        step(8'h10, 8'h03, 8'h05, 8'h07, 16'h0000, "flush_e0");
        step(8'h20, 8'h03, 8'h05, 8'h07, 16'h0030, "flush_e1");
        step(8'h30, 8'h03, 8'h05, 8'h07, 16'h00B0, "flush_e2");
        step(8'h00, 8'h03, 8'h05, 8'h07, 16'h01A0, "flush_e3");
        step(8'h00, 8'h03, 8'h05, 8'h07, 16'h01D0, "flush_e4");
        step(8'h00, 8'h03, 8'h05, 8'h07, 16'h0150, "flush_e5");
        step(8'h00, 8'h03, 8'h05, 8'h07, 16'h0000, "flush_e6");

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_filter.md
Name: fir_filter

Overview:
- 3-tap direct-form FIR filter; unsigned data and coefficients; one sample per clock, no handshake.
- Input samples pass through a registered 3-stage delay line. The weighted sum is registered at the output.
- Coefficients are static port inputs driven by the surrounding datapath/config logic.

Parameters:
- WIDTH, 8, bit width of the input sample and of each coefficient; the output is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- fir_in  input  WIDTH  input sample; sampled every rising edge
- w_1  input  WIDTH  coefficient for the newest registered sample (x1)
- w_2  input  WIDTH  coefficient for the middle sample (x2)
- w_3  input  WIDTH  coefficient for the oldest sample (x3)
- fir_out  output  2*WIDTH  filter output, registered

Behaviour:
- One clock, one reset. Reset is asynchronous and active-high: asserting rst immediately clears x1, x2, x3 and fir_out to 0.
- The outputs stay 0 while rst is high. Operation resumes on the first rising edge after deassertion.
- On each rising edge with rst low, all registers update from their pre-edge values:
  - x1 <= fir_in; x2 <= x1; x3 <= x2
  - fir_out <= (w_1*x1 + w_2*x2 + w_3*x3) mod 2^(2*WIDTH)
- Latency: a sample captured at edge k first affects fir_out at edge k+1, weighted by w_1. It is weighted by w_2 at edge k+2 and by w_3 at edge k+3, then drops out.
- Equivalent form: fir_out after edge n = w_1*x[n-1] + w_2*x[n-2] + w_3*x[n-3], where x[m] is fir_in sampled at edge m.
- Arithmetic: all operands unsigned. Each product is WIDTH x WIDTH giving 2*WIDTH bits. The 3-term sum is truncated to 2*WIDTH bits; carry-out is discarded, with no saturation.
- Coefficients are combinational into the sum; a coefficient change takes effect at the next rising edge.
- No enable and no valid signal: the filter processes every cycle.
- Reset mid-stream flushes all history; the next outputs see zeros in place of the pre-reset samples.

Decomposition:
- Shared package fir_pkg holds the default data width constant FIR_WIDTH = 8 and the tap count constant FIR_TAPS = 3.
- One natural sub-module: fir_tap_mac, which computes one product w*x at 2*WIDTH bits.
- The top instantiates three fir_tap_mac instances and the adder tree, and holds the delay-line and output registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> fir_out goes 0 immediately. Release rst with fir_in=0 -> fir_out stays 0x0000.
- Impulse response: w_1=0x5B, w_2=0xFF, w_3=0x87. Drive fir_in = FF, 00, FF, 00, 00... on successive edges starting at edge 0. Required fir_out:
  - after edge 3: 0xE11E
  - after edge 4: 0xFE01
  - after edge 5: 0x8679
  - after edge 6 onward: 0x0000
- Single impulse: fir_in=0x01 for one edge, all weights distinct (0x11, 0x22, 0x33) -> fir_out = 0x0011, 0x0022, 0x0033 on the next three edges, then 0.
- Overflow wrap: all weights 0xFF and fir_in held at 0xFF -> steady-state fir_out = (3*0xFE01) mod 2^16 = 0xFA03.
- Coefficient change: with a constant input of 0x02, switch w_2 from 0x01 to 0x10 -> fir_out reflects the new w_2 at the first edge after the change.
- Reset mid-stream: clear the history with rst, then feed samples -> the output equals the response computed from a zero-initialised delay line.
